// File: rtl/rvv_backend_dispatch_raw_tracker.sv
// rtl/rvv_backend_dispatch_raw_tracker.sv - tracks in-flight ROB destination vregs and produces per-operand bypass hits and RAW stall
module rvv_backend_dispatch_raw_tracker #(
  parameter int ROB_DEPTH  = 8,
  parameter int ROB_IDX_W  = 3,
  parameter int VREG_IDX_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alloc_valid,
  input  logic [VREG_IDX_W-1:0] alloc_vd,
  input  logic                  alloc_vd_valid,
  output logic                  alloc_ready,
  output logic [ROB_IDX_W-1:0]  alloc_idx,
  input  logic                  wb_valid,
  input  logic [ROB_IDX_W-1:0]  wb_idx,
  input  logic                  retire_valid,
  input  logic                  flush,
  input  logic                  query_valid,
  input  logic [VREG_IDX_W-1:0] query_vs1,
  input  logic [VREG_IDX_W-1:0] query_vs2,
  input  logic [VREG_IDX_W-1:0] query_vd,
  input  logic                  query_vs1_en,
  input  logic                  query_vs2_en,
  input  logic                  query_vd_en,
  input  logic                  query_v0_en,
  output logic [ROB_DEPTH-1:0]  vs1_hit,
  output logic [ROB_DEPTH-1:0]  vs2_hit,
  output logic [ROB_DEPTH-1:0]  vd_hit,
  output logic [ROB_DEPTH-1:0]  v0_hit,
  output logic                  raw_stall,
  output logic [ROB_IDX_W:0]    count
);

  logic [ROB_DEPTH-1:0]                 valid_q;
  logic [ROB_DEPTH-1:0]                 done_q;
  logic [ROB_DEPTH-1:0]                 vd_valid_q;
  logic [ROB_DEPTH-1:0][VREG_IDX_W-1:0] vd_q;
  logic [ROB_IDX_W-1:0]                 wptr_q;
  logic [ROB_IDX_W-1:0]                 rptr_q;
  logic [ROB_IDX_W:0]                   count_q;
  logic                                 alloc_fire;
  logic                                 retire_fire;

  assign alloc_ready = (count_q != (ROB_IDX_W+1)'(ROB_DEPTH));
  assign alloc_idx   = wptr_q;
  assign count       = count_q;
  assign alloc_fire  = alloc_valid & alloc_ready & ~flush;
  assign retire_fire = retire_valid & (count_q != '0) & ~flush;

  // Retire and alloc follow writeback so a same-cycle retire clears done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      done_q     <= '0;
      vd_valid_q <= '0;
      vd_q       <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else if (flush) begin
      valid_q <= '0;
      done_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wb_valid && valid_q[wb_idx]) begin
        done_q[wb_idx] <= 1'b1;
      end
      if (retire_fire) begin
        valid_q[rptr_q] <= 1'b0;
        done_q[rptr_q]  <= 1'b0;
        rptr_q          <= rptr_q + 1'b1;
      end
      if (alloc_fire) begin
        valid_q[wptr_q]    <= 1'b1;
        done_q[wptr_q]     <= 1'b0;
        vd_q[wptr_q]       <= alloc_vd;
        vd_valid_q[wptr_q] <= alloc_vd_valid;
        wptr_q             <= wptr_q + 1'b1;
      end
      case ({alloc_fire, retire_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Walk entries in age order starting from the youngest (wptr-1); first match wins.
  function automatic logic [ROB_DEPTH-1:0] youngest_hit(
    input logic                                 en,
    input logic [VREG_IDX_W-1:0]                vreg,
    input logic [ROB_IDX_W-1:0]                 wptr,
    input logic [ROB_DEPTH-1:0]                 valid,
    input logic [ROB_DEPTH-1:0]                 vd_valid,
    input logic [ROB_DEPTH-1:0][VREG_IDX_W-1:0] vd
  );
    logic [ROB_DEPTH-1:0] hit;
    logic                 found;
    logic [ROB_IDX_W-1:0] idx;
    hit   = '0;
    found = 1'b0;
    for (int k = 0; k < ROB_DEPTH; k++) begin
      idx = wptr - ROB_IDX_W'(k + 1);
      if (!found && en && valid[idx] && vd_valid[idx] && (vd[idx] == vreg)) begin
        hit[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return hit;
  endfunction

  always_comb begin
    vs1_hit = youngest_hit(query_valid & query_vs1_en, query_vs1, wptr_q, valid_q, vd_valid_q, vd_q);
    vs2_hit = youngest_hit(query_valid & query_vs2_en, query_vs2, wptr_q, valid_q, vd_valid_q, vd_q);
    vd_hit  = youngest_hit(query_valid & query_vd_en, query_vd, wptr_q, valid_q, vd_valid_q, vd_q);
    v0_hit  = youngest_hit(query_valid & query_v0_en, '0, wptr_q, valid_q, vd_valid_q, vd_q);
  end

  assign raw_stall = query_valid & (|((vs1_hit | vs2_hit | vd_hit | v0_hit) & ~done_q));

endmodule

// File: tb/tb_rvv_backend_dispatch_raw_tracker.sv
// tb/tb_rvv_backend_dispatch_raw_tracker.sv - directed bench with a queue-based ROB model checked every cycle
module tb_rvv_backend_dispatch_raw_tracker;

  logic       clk;
  logic       rst_n;
  logic       alloc_valid;
  logic [4:0] alloc_vd;
  logic       alloc_vd_valid;
  logic       alloc_ready;
  logic [2:0] alloc_idx;
  logic       wb_valid;
  logic [2:0] wb_idx;
  logic       retire_valid;
  logic       flush;
  logic       query_valid;
  logic [4:0] query_vs1, query_vs2, query_vd;
  logic       query_vs1_en, query_vs2_en, query_vd_en, query_v0_en;
  logic [7:0] vs1_hit, vs2_hit, vd_hit, v0_hit;
  logic       raw_stall;
  logic [3:0] count;

  int vectors = 0;
  int miscompares = 0;

  rvv_backend_dispatch_raw_tracker dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_vd(alloc_vd), .alloc_vd_valid(alloc_vd_valid),
    .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .retire_valid(retire_valid), .flush(flush),
    .query_valid(query_valid), .query_vs1(query_vs1), .query_vs2(query_vs2), .query_vd(query_vd),
    .query_vs1_en(query_vs1_en), .query_vs2_en(query_vs2_en), .query_vd_en(query_vd_en),
    .query_v0_en(query_v0_en),
    .vs1_hit(vs1_hit), .vs2_hit(vs2_hit), .vd_hit(vd_hit), .v0_hit(v0_hit),
    .raw_stall(raw_stall), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: in-flight uops oldest-first; an entry's ROB index follows from its position and mptr.
  typedef struct packed {
    logic [4:0] vd;
    logic       vv;
    logic       done;
  } ent_t;

  ent_t q[$];
  int   mptr = 0;

  function automatic int ent_idx(input int i);
    return (mptr - q.size() + i) & 7;
  endfunction

  function automatic void lookup(input logic en, input logic [4:0] r,
                                 output logic [7:0] hit, output logic pend);
    hit  = '0;
    pend = 1'b0;
    if (query_valid && en) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].vv && q[i].vd == r) begin
          hit[ent_idx(i)] = 1'b1;
          pend            = !q[i].done;
          break;
        end
      end
    end
  endfunction

  always @(negedge rst_n) begin
    q.delete();
    mptr = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (flush) begin
        q.delete();
        mptr = 0;
      end else begin
        int n;
        n = q.size();
        if (wb_valid)
          for (int i = 0; i < n; i++)
            if (ent_idx(i) == int'(wb_idx)) q[i].done = 1'b1;
        if (retire_valid && n > 0) void'(q.pop_front());
        if (alloc_valid && n < 8) begin
          q.push_back(ent_t'{alloc_vd, alloc_vd_valid, 1'b0});
          mptr = (mptr + 1) & 7;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] h1, h2, h3, h0;
    logic       p1, p2, p3, p0;
    lookup(query_vs1_en, query_vs1, h1, p1);
    lookup(query_vs2_en, query_vs2, h2, p2);
    lookup(query_vd_en, query_vd, h3, p3);
    lookup(query_v0_en, 5'd0, h0, p0);
    chk("m_vs1_hit", vs1_hit, h1);
    chk("m_vs2_hit", vs2_hit, h2);
    chk("m_vd_hit", vd_hit, h3);
    chk("m_v0_hit", v0_hit, h0);
    chk("m_raw_stall", raw_stall, p1 | p2 | p3 | p0);
    chk("m_count", count, q.size());
    chk("m_alloc_ready", alloc_ready, q.size() != 8);
    chk("m_alloc_idx", alloc_idx, mptr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    alloc_valid  = 1'b0;
    wb_valid     = 1'b0;
    retire_valid = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic do_alloc(input logic [4:0] vd, input logic vv);
    alloc_valid = 1'b1; alloc_vd = vd; alloc_vd_valid = vv;
    tick();
  endtask

  task automatic do_wb(input logic [2:0] idx);
    wb_valid = 1'b1; wb_idx = idx;
    tick();
  endtask

  task automatic do_retire();
    retire_valid = 1'b1;
    tick();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
  endtask

  task automatic setq(input logic qv, input logic [4:0] s1, input logic e1,
                      input logic [4:0] s2, input logic e2,
                      input logic [4:0] d, input logic e3, input logic e0);
    query_valid = qv;
    query_vs1 = s1; query_vs1_en = e1;
    query_vs2 = s2; query_vs2_en = e2;
    query_vd  = d;  query_vd_en  = e3;
    query_v0_en = e0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    alloc_valid = 0; alloc_vd = 0; alloc_vd_valid = 0;
    wb_valid = 0; wb_idx = 0; retire_valid = 0; flush = 0;
    query_valid = 0; query_vs1 = 0; query_vs2 = 0; query_vd = 0;
    query_vs1_en = 0; query_vs2_en = 0; query_vd_en = 0; query_v0_en = 0;
    #2;
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_alloc_idx", alloc_idx, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // single producer: pending then written back
    do_alloc(5'd3, 1'b1);
    setq(1, 5'd3, 1, 0, 0, 0, 0, 0);
    chk("t1_vs1_hit", vs1_hit, 8'h01);
    chk("t1_stall", raw_stall, 1);
    do_wb(3'd0);
    chk("t1_stall_wb", raw_stall, 0);
    chk("t1_vs1_hit_wb", vs1_hit, 8'h01);
    setq(0, 5'd3, 1, 0, 0, 0, 0, 0);
    chk("t1_noquery", vs1_hit, 8'h00);

    // youngest of three writers, then retire past it
    do_flush();
    for (int i = 0; i < 3; i++) do_alloc(5'd5, 1'b1);
    for (int i = 0; i < 3; i++) do_wb(3'(i));
    setq(1, 0, 0, 5'd5, 1, 0, 0, 0);
    chk("t2_vs2_hit", vs2_hit, 8'h04);
    chk("t2_stall", raw_stall, 0);
    do_retire(); do_retire();
    chk("t2_vs2_hit_r2", vs2_hit, 8'h04);
    do_retire();
    chk("t2_vs2_hit_r3", vs2_hit, 8'h00);
    chk("t2_count", count, 0);

    // wrap-around: age order beats index order
    do_flush();
    for (int k = 0; k < 8; k++) do_alloc((k == 6) ? 5'd7 : 5'(10 + k), 1'b1);
    chk("t3_full_ready", alloc_ready, 0);
    chk("t3_full_count", count, 8);
    do_alloc(5'd7, 1'b1);
    chk("t3_full_ignored", count, 8);
    do_wb(3'd6);
    for (int i = 0; i < 3; i++) do_retire();
    do_alloc(5'd7, 1'b1);
    do_alloc(5'd7, 1'b1);
    do_wb(3'd1);
    setq(1, 0, 0, 0, 0, 5'd7, 1, 0);
    chk("t3_vd_hit", vd_hit, 8'h02);
    chk("t3_stall", raw_stall, 0);

    // full with same-cycle retire: alloc still refused
    do_alloc(5'd20, 1'b1);
    chk("t4_full", count, 8);
    alloc_valid = 1'b1; alloc_vd = 5'd21; alloc_vd_valid = 1'b1; retire_valid = 1'b1;
    tick();
    chk("t4_count", count, 7);
    chk("t4_ready", alloc_ready, 1);
    chk("t4_idx", alloc_idx, 3);
    do_alloc(5'd21, 1'b1);
    chk("t4_count_after", count, 8);
    chk("t4_idx_after", alloc_idx, 4);

    // v0 operand and vd_valid gating
    do_flush();
    do_alloc(5'd0, 1'b0);
    setq(1, 0, 0, 0, 0, 0, 0, 1);
    chk("t5_v0_novalid", v0_hit, 8'h00);
    chk("t5_stall_novalid", raw_stall, 0);
    do_alloc(5'd0, 1'b1);
    chk("t5_v0_hit", v0_hit, 8'h02);
    chk("t5_stall", raw_stall, 1);
    setq(1, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_v0_off", v0_hit, 8'h00);
    chk("t5_stall_off", raw_stall, 0);

    // flush overrides same-cycle alloc and wb
    alloc_valid = 1'b1; alloc_vd = 5'd9; alloc_vd_valid = 1'b1;
    wb_valid = 1'b1; wb_idx = 3'd1; flush = 1'b1;
    tick();
    setq(1, 5'd9, 1, 5'd0, 1, 5'd0, 1, 1);
    chk("t6_count", count, 0);
    chk("t6_idx", alloc_idx, 0);
    chk("t6_hits", {vs1_hit, vs2_hit, vd_hit, v0_hit}, 32'h0);

    // mixed traffic checked by the model every cycle
    for (int c = 0; c < 80; c++) begin
      query_valid  = 1'b1;
      query_vs1    = 5'($urandom_range(0, 3)); query_vs1_en = 1'($urandom);
      query_vs2    = 5'($urandom_range(0, 3)); query_vs2_en = 1'($urandom);
      query_vd     = 5'($urandom_range(0, 3)); query_vd_en  = 1'($urandom);
      query_v0_en  = 1'($urandom);
      alloc_valid  = ($urandom_range(0, 3) != 0);
      alloc_vd     = 5'($urandom_range(0, 3));
      alloc_vd_valid = ($urandom_range(0, 4) != 0);
      wb_valid     = 1'($urandom);
      wb_idx       = 3'($urandom);
      retire_valid = ($urandom_range(0, 2) == 0);
      flush        = ($urandom_range(0, 30) == 0);
      tick();
    end

    // asynchronous reset mid-stream
    do_alloc(5'd2, 1'b1);
    do_alloc(5'd2, 1'b1);
    setq(1, 5'd2, 1, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("t7_count", count, 0);
    chk("t7_idx", alloc_idx, 0);
    chk("t7_ready", alloc_ready, 1);
    chk("t7_hit", vs1_hit, 8'h00);
    chk("t7_stall", raw_stall, 0);
    tick();
    rst_n = 1'b1;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
